pll_lock_supervisor: RTL



---
 rtl/pll_sup_pkg.sv | 30 +++
 rtl/pll_lock_chan.sv | 150 +++++++++++++++
 rtl/pll_lock_supervisor.sv | 58 +++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types, defaults and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    // Per-channel supervisor state.
    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_sup_state_t;

    localparam int DEF_N_PLL            = 2;
    localparam int DEF_RST_HOLD_CYC     = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_MAX_RETRY        = 3;

    // Width of the shared cycle counter: large enough to hold the longest
    // per-state interval without wrapping.
    function automatic int ctr_width(input int hold_cyc, input int timeout_cyc,
                                     input int stable_cyc);
        int max_val;
        max_val = hold_cyc;
        if (timeout_cyc > max_val) max_val = timeout_cyc;
        if (stable_cyc > max_val)  max_val = stable_cyc;
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_lock_chan.sv
// One supervised PLL channel: lock synchroniser, acquisition FSM with retry
// accounting, and registered outputs decoded from the next state.
module pll_lock_chan
    import pll_sup_pkg::*;
#(
    parameter int RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
    input  logic clkin1,
    input  logic rst_n,
    input  logic pll_lock,
    input  logic fault_clr,
    output logic pll_rst,
    output logic dom_rst_n,
    output logic fault,
    output logic lock_lost
);

    localparam int CW = ctr_width(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
    localparam int RW = $clog2(MAX_RETRY + 1);

    // Terminal counts: cnt counts cycles already spent in the state, so the
    // exit happens on the edge where cnt reaches N-1.
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_HOLD_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);

    logic [1:0]     sync_reg;
    logic           lock_s;
    pll_sup_state_t state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [RW-1:0]  retry_reg, retry_next;
    logic [RW-1:0]  retry_inc;
    logic           lock_lost_reg, lock_lost_next;
    logic           pll_rst_reg, dom_rst_n_reg, fault_reg;
    logic           failed;

    assign lock_s    = sync_reg[1];
    assign retry_inc = retry_reg + RW'(1);

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clkin1) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], pll_lock};
        end
    end

    // State, counters and registered outputs (outputs follow the next state).
    always_ff @(posedge clkin1) begin
        if (!rst_n) begin
            state_reg     <= ST_RESET;
            cnt_reg       <= '0;
            retry_reg     <= '0;
            lock_lost_reg <= 1'b0;
            pll_rst_reg   <= 1'b1;
            dom_rst_n_reg <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            retry_reg     <= retry_next;
            lock_lost_reg <= lock_lost_next;
            pll_rst_reg   <= (state_next == ST_RESET) || (state_next == ST_FAULT);
            dom_rst_n_reg <= (state_next == ST_RUN);
            fault_reg     <= (state_next == ST_FAULT);
        end
    end

    // Next-state logic; a failed attempt is resolved after the case so that
    // WAIT_LOCK timeouts and STABLE glitches share the retry accounting.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        retry_next     = retry_reg;
        lock_lost_next = fault_clr ? 1'b0 : lock_lost_reg;
        failed         = 1'b0;

        case (state_reg)
            ST_RESET: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = ST_STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    failed = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    failed = 1'b1;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                    retry_next = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_RUN: begin
                // A loss after a good lock restarts acquisition with a clean
                // retry budget; it is reported but never counted as a failure.
                if (!lock_s) begin
                    state_next     = ST_RESET;
                    cnt_next       = '0;
                    retry_next     = '0;
                    lock_lost_next = 1'b1;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_next     = ST_RESET;
                    cnt_next       = '0;
                    retry_next     = '0;
                    lock_lost_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_RESET;
                cnt_next   = '0;
                retry_next = '0;
            end
        endcase

        if (failed) begin
            retry_next = retry_inc;
            cnt_next   = '0;
            state_next = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_RESET;
        end
    end

    assign pll_rst   = pll_rst_reg;
    assign dom_rst_n = dom_rst_n_reg;
    assign fault     = fault_reg;
    assign lock_lost = lock_lost_reg;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Top level: N_PLL independent channel supervisors plus the registered
// all-channels-locked summary.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int N_PLL            = DEF_N_PLL,
    parameter int RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
    input  logic             clkin1,
    input  logic             rst_n,
    input  logic [N_PLL-1:0] pll_lock,
    input  logic [N_PLL-1:0] fault_clr,
    output logic [N_PLL-1:0] pll_rst,
    output logic [N_PLL-1:0] dom_rst_n,
    output logic [N_PLL-1:0] fault,
    output logic [N_PLL-1:0] lock_lost,
    output logic             all_locked
);

    logic all_locked_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_PLL; gi++) begin : g_chan
            pll_lock_chan #(
                .RST_HOLD_CYC     (RST_HOLD_CYC),
                .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
                .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
                .MAX_RETRY        (MAX_RETRY)
            ) u_chan (
                .clkin1    (clkin1),
                .rst_n     (rst_n),
                .pll_lock  (pll_lock[gi]),
                .fault_clr (fault_clr[gi]),
                .pll_rst   (pll_rst[gi]),
                .dom_rst_n (dom_rst_n[gi]),
                .fault     (fault[gi]),
                .lock_lost (lock_lost[gi])
            );
        end
    endgenerate

    // dom_rst_n is high exactly while a channel is in RUN, so its AND
    // (registered once more) is the all-channels-running flag.
    always_ff @(posedge clkin1) begin
        if (!rst_n) begin
            all_locked_reg <= 1'b0;
        end else begin
            all_locked_reg <= &dom_rst_n;
        end
    end

    assign all_locked = all_locked_reg;

endmodule
